// File: rtl/ram_1r4w_lvt.sv
// ram_1r4w_lvt: four-write / one-read 32-bit memory built from one bank per
// write port plus a Live Value Table (LVT) that remembers which bank holds the
// most recent write for each address. Reads are registered (latency 1) and
// read-before-write by default.
// Optional feature macro: RAM_WR_BYPASS_EN -- when defined, a read that hits
// an address written in the same cycle returns the new (winning-port) data.
// Reset (rst) is synchronous and active-low.
module ram_1r4w_lvt #(
    parameter int BLOCKSIZE = 10,
    parameter int CNTW      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BLOCKSIZE:0]   w_addr_1,
    input  logic [BLOCKSIZE:0]   w_addr_2,
    input  logic [BLOCKSIZE:0]   w_addr_3,
    input  logic [BLOCKSIZE:0]   w_addr_4,
    input  logic [31:0]          w_din_1,
    input  logic [31:0]          w_din_2,
    input  logic [31:0]          w_din_3,
    input  logic [31:0]          w_din_4,
    input  logic                 w_enb_1,
    input  logic                 w_enb_2,
    input  logic                 w_enb_3,
    input  logic                 w_enb_4,
    input  logic [BLOCKSIZE:0]   r_addr_1,
    output logic [31:0]          r_dout_1,
    output logic                 w_conflict,
    output logic [CNTW-1:0]      conflict_cnt
);
    localparam int AW    = BLOCKSIZE + 1;
    localparam int DEPTH = 2 ** AW;

    // Gather the write ports into arrays so the banks can be generated.
    logic [AW-1:0] w_addr [4];
    logic [31:0]   w_din  [4];
    logic [3:0]    w_enb;

    assign w_addr[0] = w_addr_1;
    assign w_addr[1] = w_addr_2;
    assign w_addr[2] = w_addr_3;
    assign w_addr[3] = w_addr_4;
    assign w_din[0]  = w_din_1;
    assign w_din[1]  = w_din_2;
    assign w_din[2]  = w_din_3;
    assign w_din[3]  = w_din_4;
    assign w_enb     = {w_enb_4, w_enb_3, w_enb_2, w_enb_1};

    // Registered read data of each bank (old contents on same-address write).
    logic [31:0] bank_q [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bank
            logic [31:0] mem [DEPTH];
            logic [31:0] rd_q_reg;

            // One 1R1W bank per write port; writes are dropped during reset.
            always_ff @(posedge clk) begin
                if (rst && w_enb[gi]) begin
                    mem[w_addr[gi]] <= w_din[gi];
                end
                rd_q_reg <= mem[r_addr_1];
            end

            assign bank_q[gi] = rd_q_reg;
        end
    endgenerate

    // LVT: later loop iterations override earlier ones, so port 4 wins ties.
    logic [1:0] lvt_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                lvt_reg[i] <= 2'd0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (w_enb[k]) begin
                    lvt_reg[w_addr[k]] <= 2'(k);
                end
            end
        end
    end

    // Capture the bank selector alongside the bank reads; force zero output after reset.
    logic [1:0] sel_reg;
    logic       zero_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sel_reg  <= 2'd0;
            zero_reg <= 1'b1;
        end else begin
            sel_reg  <= lvt_reg[r_addr_1];
            zero_reg <= 1'b0;
        end
    end

    // A conflict is any pair of enabled ports targeting the same address.
    logic conflict_next;

    always_comb begin
        conflict_next = 1'b0;
        for (int a = 0; a < 3; a++) begin
            for (int b = a + 1; b < 4; b++) begin
                if (w_enb[a] && w_enb[b] && (w_addr[a] == w_addr[b])) begin
                    conflict_next = 1'b1;
                end
            end
        end
    end

    // Conflict pulse and saturating conflict counter (one count per cycle).
    logic            w_conflict_reg;
    logic [CNTW-1:0] conflict_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            w_conflict_reg   <= 1'b0;
            conflict_cnt_reg <= '0;
        end else begin
            w_conflict_reg <= conflict_next;
            if (conflict_next && (conflict_cnt_reg != {CNTW{1'b1}})) begin
                conflict_cnt_reg <= conflict_cnt_reg + CNTW'(1);
            end
        end
    end

    assign w_conflict   = w_conflict_reg;
    assign conflict_cnt = conflict_cnt_reg;

`ifdef RAM_WR_BYPASS_EN
    // Same-cycle write to the read address: highest-numbered matching port wins.
    logic        byp_hit_next;
    logic [31:0] byp_data_next;
    logic        byp_hit_reg;
    logic [31:0] byp_data_reg;

    always_comb begin
        byp_hit_next  = 1'b0;
        byp_data_next = 32'd0;
        for (int k = 0; k < 4; k++) begin
            if (w_enb[k] && (w_addr[k] == r_addr_1)) begin
                byp_hit_next  = 1'b1;
                byp_data_next = w_din[k];
            end
        end
    end

    // Register the bypass decision in step with the bank reads.
    always_ff @(posedge clk) begin
        if (!rst) begin
            byp_hit_reg  <= 1'b0;
            byp_data_reg <= 32'd0;
        end else begin
            byp_hit_reg  <= byp_hit_next;
            byp_data_reg <= byp_data_next;
        end
    end

    assign r_dout_1 = zero_reg    ? 32'd0 :
                      byp_hit_reg ? byp_data_reg : bank_q[sel_reg];
`else
    assign r_dout_1 = zero_reg ? 32'd0 : bank_q[sel_reg];
`endif

endmodule
